// File: rtl/ldw_mem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU MEM stage and a DMA reader.
// ARB_RR_EN selects round-robin arbitration instead of CPU priority with a starvation counter.
module ldw_mem_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [31:0]       dma_addr,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } own_e;

    own_e rd_own;
    own_e rd_own_nxt;
    logic cpu_gnt_c;
    logic dma_gnt_c;

    // Only the word-address slice of each byte address reaches the RAM.
    logic unused_addr;
    assign unused_addr = ^{cpu_addr, dma_addr};

`ifdef ARB_RR_EN
    logic        last_dma;
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(MAX_WAIT + CNT_W);

    // On contention the requester that lost the previous contention wins.
    always_comb begin
        cpu_gnt_c = 1'b0;
        dma_gnt_c = 1'b0;
        if (cpu_req && dma_req) begin
            cpu_gnt_c = last_dma;
            dma_gnt_c = !last_dma;
        end else begin
            cpu_gnt_c = cpu_req;
            dma_gnt_c = dma_req;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_dma <= 1'b1;
        end else if (cpu_req && dma_req) begin
            last_dma <= dma_gnt_c;
        end
    end
`else
    logic [CNT_W-1:0] wait_cnt;
    logic             force_c;

    // CPU wins unless the DMA has been denied MAX_WAIT cycles in a row.
    always_comb begin
        force_c   = dma_req && (wait_cnt == CNT_W'(MAX_WAIT));
        cpu_gnt_c = cpu_req && !force_c;
        dma_gnt_c = dma_req && !cpu_gnt_c;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (!dma_req || dma_gnt_c) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`endif

    assign cpu_stall = cpu_req && !cpu_gnt_c;
    assign dma_gnt   = dma_gnt_c;

    // RAM port mux; idle cycles present a zero address with writes disabled.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt_c) begin
            mem_we    = cpu_we && resetn;
            mem_addr  = cpu_addr[ADDR_W+1:2];
            mem_wdata = cpu_wdata;
        end else if (dma_gnt_c) begin
            mem_addr  = dma_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        rd_own_nxt = OWN_NONE;
        if (cpu_gnt_c && !cpu_we) begin
            rd_own_nxt = OWN_CPU;
        end else if (dma_gnt_c) begin
            rd_own_nxt = OWN_DMA;
        end
    end

    // Remembers who issued the read whose data arrives from the RAM this cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_own <= OWN_NONE;
        end else begin
            rd_own <= rd_own_nxt;
        end
    end

    assign dma_rvalid = (rd_own == OWN_DMA);
    assign dma_rdata  = (rd_own == OWN_DMA) ? mem_rdata : 32'd0;
    assign cpu_rdata  = (rd_own == OWN_CPU) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_ldw_mem_arbiter.sv
// Randomized bench for ldw_mem_arbiter against a transaction-level model with a shadow memory.
module tb_ldw_mem_arbiter;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic              clock;
    logic              resetn;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              dma_req;
    logic [31:0]       dma_addr;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    ldw_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        if (i == 8) return 32'h1234_5678;
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Synchronous RAM with one cycle of read latency, fed from the arbiter's RAM port.
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_q;
    assign mem_rdata = ram_q;

    initial begin : ram_model
        logic              we_l;
        logic [ADDR_W-1:0] a_l;
        logic [31:0]       wd_l;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = init_word(i);
        ram_q = 32'd0;
        forever begin
            @(negedge clock);
            #2;
            we_l = mem_we;
            a_l  = mem_addr;
            wd_l = mem_wdata;
            @(posedge clock);
            ram_q = ram[a_l];
            if (we_l) ram[a_l] = wd_l;
        end
    end

    // Reference model state: shadow memory, pending read, DMA denial streak, last contention winner.
    logic [31:0] ref_mem [DEPTH];
    int          pend;        // 0 none, 1 cpu, 2 dma
    logic [31:0] pend_data;
    int          denied;
    bit          last_dma;
    int          checks;
    int          failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend     = 0;
        denied   = 0;
        last_dma = 1'b1;
    endtask

    // Drives one cycle of requests, checks every output against the model, then advances the model.
    task automatic cycle(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwdata, input logic dreq, input logic [31:0] daddr,
                         output logic got_dgnt, output logic got_stall);
        logic cg, dg;
        logic [ADDR_W-1:0] cidx, didx, eaddr;
        @(negedge clock);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwdata;
        dma_req = dreq; dma_addr = daddr;
        #1;
        cidx = caddr[ADDR_W+1:2];
        didx = daddr[ADDR_W+1:2];
`ifdef ARB_RR_EN
        cg = (creq && dreq) ? last_dma : creq;
`else
        cg = creq && !(dreq && denied == int'(MAX_WAIT));
`endif
        dg = dreq && !cg;
        eaddr = cg ? cidx : (dg ? didx : '0);

        check("cpu_stall", 32'(cpu_stall), 32'(creq && !cg));
        check("dma_gnt", 32'(dma_gnt), 32'(dg));
        check("mem_we", 32'(mem_we), 32'(cg && cwe));
        check("mem_addr", 32'(mem_addr), 32'(eaddr));
        if (cg && cwe) check("mem_wdata", mem_wdata, cwdata);
        check("dma_rvalid", 32'(dma_rvalid), 32'(pend == 2));
        check("dma_rdata", dma_rdata, (pend == 2) ? pend_data : 32'd0);
        check("cpu_rdata", cpu_rdata, (pend == 1) ? pend_data : 32'd0);
        got_dgnt  = dma_gnt;
        got_stall = cpu_stall;

        if (cg && cwe) begin
            ref_mem[cidx] = cwdata;
            pend = 0;
        end else if (cg) begin
            pend = 1;
            pend_data = ref_mem[cidx];
        end else if (dg) begin
            pend = 2;
            pend_data = ref_mem[didx];
        end else begin
            pend = 0;
        end
        if (dreq && !dg) denied = (denied < int'(MAX_WAIT)) ? denied + 1 : denied;
        else denied = 0;
        if (creq && dreq) last_dma = dg;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [ADDR_W-1:0] w;
        r = $urandom();
        w = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom()) : ADDR_W'($urandom_range(0, 31));
        return {r[31:ADDR_W+2], w, 2'b00};
    endfunction

    initial begin : main
        logic g, s;
        int dma_cnt, first_dma;
        logic c_req, c_we, d_req;
        logic [31:0] c_addr, c_wdata, d_addr;

        checks = 0;
        failures = 0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        model_reset();
        resetn = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_addr = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Store then load the same word; load data appears the cycle after the load.
        cycle(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, g, s);
        cycle(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, g, s);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, g, s);
        check("store_load_data", ref_mem[4], 32'hDEAD_BEEF);
        // Lone DMA read of word 8, then CPU load directly followed by a DMA read.
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h20, g, s);
        cycle(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 32'd0, g, s);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h48, g, s);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, g, s);

        // Reset lands while a DMA read is in flight.
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h20, g, s);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0;
        #1;
        check("inflight_rvalid", 32'(dma_rvalid), 32'd0);
        check("inflight_rdata", dma_rdata, 32'd0);
        check("inflight_mem_we", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        model_reset();

        // Both requesters held high: starvation forcing or strict alternation.
        dma_cnt = 0;
        first_dma = -1;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b1, 1'b0, 32'h80, 32'd0, 1'b1, 32'h100 + 32'(i * 4), g, s);
            if (g) begin
                dma_cnt++;
                if (first_dma < 0) first_dma = i;
            end
        end
`ifdef ARB_RR_EN
        check("held_dma_count", 32'(dma_cnt), 32'd9);
        check("held_first_dma", 32'(first_dma), 32'd1);
`else
        check("held_dma_count", 32'(dma_cnt), 32'd2);
        check("held_first_dma", 32'(first_dma), 32'd8);
`endif

        // Random traffic; a stalled CPU and an ungranted DMA keep their requests stable.
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0;
        d_req = 1'b0; d_addr = 32'd0;
        s = 1'b0;
        g = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!(c_req && s)) begin
                c_req   = ($urandom_range(0, 99) < 65);
                c_we    = ($urandom_range(0, 99) < 40);
                c_addr  = rand_addr();
                c_wdata = $urandom();
            end
            if (!(d_req && !g)) begin
                d_req  = ($urandom_range(0, 99) < 50);
                d_addr = rand_addr();
            end
            cycle(c_req, c_we, c_addr, c_wdata, d_req, d_addr, g, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
